// File: rtl/l2_write_buffer.sv
// Line-granular write buffer between the cache arbiter and the unified L2.
// Writes retire into a small FIFO and drain in the background; reads get priority.
module l2_write_buffer #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  input  logic [s_line-1:0] mem_wdata,
  output logic              mem_resp,
  output logic [s_line-1:0] mem_rdata,
  output logic              l2_read,
  output logic              l2_write,
  output logic [31:0]       l2_address,
  output logic [s_line-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [s_line-1:0] l2_rdata,
  output logic              buffer_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = 32 - s_offset;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t state, state_n;

  logic [DEPTH-1:0]  valid;
  logic [TW-1:0]     tags [DEPTH];
  logic [s_line-1:0] data [DEPTH];
  logic [PW-1:0]     head, tail, hit_idx;
  logic [CW-1:0]     count, cnt_eff;
  logic [TW-1:0]     tag;
  logic              hit, pop, req_ok;
  logic              rd_hit, rd_miss, rd_done;
  logic              w_hit, blocked, wr_req;
  logic              wr_coal, wr_push;
  logic              addr_unused;

  assign tag         = mem_address[31:s_offset];
  assign addr_unused = ^mem_address[s_offset-1:0];

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && tags[i] == tag) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  assign pop     = (state == DRAIN) && l2_resp;
  assign rd_done = (state == READ) && l2_resp;
  assign req_ok  = !mem_resp;
  assign cnt_eff = count - CW'(pop);

  assign rd_hit  = req_ok && mem_read && hit;
  assign rd_miss = req_ok && mem_read && !hit;
  assign wr_req  = req_ok && mem_write && !mem_read;

  // A head entry popped this cycle no longer counts as a match
  assign w_hit   = hit && !(pop && hit_idx == head);
  assign blocked = w_hit && (state == DRAIN) && (hit_idx == head);
  assign wr_coal = wr_req && w_hit && !blocked;
  assign wr_push = wr_req && !w_hit && (cnt_eff < CW'(DEPTH));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (rd_miss)
          state_n = READ;
        else if (count != '0)
          state_n = DRAIN;
      end
      READ:    if (l2_resp) state_n = IDLE;
      DRAIN:   if (l2_resp) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      l2_address <= '0;
      l2_wdata   <= '0;
      mem_resp   <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      state    <= state_n;
      l2_read  <= (state_n == READ);
      l2_write <= (state_n == DRAIN);
      if (state == IDLE && state_n == READ)
        l2_address <= {tag, {s_offset{1'b0}}};
      if (state == IDLE && state_n == DRAIN) begin
        l2_address <= {tags[head], {s_offset{1'b0}}};
        // Same-cycle coalesce into head must reach L2
        l2_wdata <= (wr_coal && hit_idx == head)
                    ? mem_wdata : data[head];
      end
      mem_resp <= wr_coal || wr_push || rd_hit || rd_done;
      if (rd_hit)
        mem_rdata <= data[hit_idx];
      else if (rd_done)
        mem_rdata <= l2_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (wr_push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      count <= cnt_eff + CW'(wr_push);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_push) begin
      tags[tail] <= tag;
      data[tail] <= mem_wdata;
    end
    if (wr_coal)
      data[hit_idx] <= mem_wdata;
  end

  assign buffer_empty = (count == '0) && (state != DRAIN);

endmodule
